sprite_line_writer: RTL

- Downstream consumer of the sprite tile table. For one sprite on the current scanline it pulses the table's load, then steps current_tile from 0 to size_x.
- For each tile it serialises the returned 32-bit row (8 pixels x 4-bit) into single-pixel writes to the sprite line buffer.
- Index 0 is transparent and is skipped. Off-screen pixels are clipped.
- The sprite evaluator drives one start per visible sprite and waits for done before issuing the next.

---
 rtl/gpu_pkg.sv | 23 ++
 rtl/sprite_line_writer_shifter.sv | 42 ++++
 rtl/sprite_line_writer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gpu_pkg                                                            |
// | Shared tile geometry, pixel format and sprite writer state codes.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gpu_pkg;

   localparam int TILE_PIXELS = 8;
   localparam int PIX_W       = 4;
   localparam int ROW_W       = TILE_PIXELS * PIX_W;

   localparam logic [PIX_W-1:0] TRANSPARENT_IDX = '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FETCH = 2'd2,
      ST_PIX   = 2'd3
   } writer_state_e;

endpackage
`default_nettype wire

// File: rtl/sprite_line_writer_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tile_pixel_shifter                                                 |
// | Serialises one tile row MSB-first; pixel 0 bypasses the register.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tile_pixel_shifter
   import gpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [ROW_W-1:0] i_row,
   output logic [PIX_W-1:0] o_pixel
);

   logic [ROW_W-1:0] shift_q;
   logic [ROW_W-1:0] shift_d;

   // On load the register already holds pixel 1 at the top, since pixel 0 is taken from i_row.
   always_comb begin
      shift_d = shift_q;
      if (i_load) begin
         shift_d = i_row << PIX_W;
      end else if (i_shift) begin
         shift_d = shift_q << PIX_W;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign o_pixel = i_load ? i_row[ROW_W-1 -: PIX_W] : shift_q[ROW_W-1 -: PIX_W];

endmodule
`default_nettype wire

// File: rtl/sprite_line_writer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sprite_line_writer                                                 |
// | Walks a sprite's tiles and writes opaque, on-screen pixels to the  |
// | line buffer. Define PREFETCH_EN to overlap tile fetch with pixel 7.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sprite_line_writer
   import gpu_pkg::*;
#(
   parameter int LINE_PIXELS = 320,
   parameter int XW          = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [XW-1:0]    sprite_x,
   input  logic [2:0]       size_x,
   output logic             busy,
   output logic             done,
   output logic             tile_load,
   output logic [3:0]       current_tile,
   input  logic [ROW_W-1:0] tile_data,
   output logic             lb_we,
   output logic [XW-1:0]    lb_addr,
   output logic [PIX_W-1:0] lb_wdata
);

   localparam logic [XW+3:0] c_LINE_LIMIT = LINE_PIXELS[XW+3:0];

   writer_state_e state_q, state_d;
   logic [XW-1:0] sprite_x_q, sprite_x_d;
   logic [2:0]    size_x_q, size_x_d;
   logic [2:0]    t_q, t_d;
   logic [2:0]    p_q, p_d;
   logic          done_q, done_d;
   logic [3:0]    current_tile_q, current_tile_d;

   logic             w_load;
   logic             w_shift;
   logic             w_in_pix;
   logic [PIX_W-1:0] w_pixel;
   logic [XW+3:0]    w_x;

   always_comb begin
      state_d        = state_q;
      sprite_x_d     = sprite_x_q;
      size_x_d       = size_x_q;
      t_d            = t_q;
      p_d            = p_q;
      done_d         = 1'b0;
      current_tile_d = current_tile_q;
      w_load         = 1'b0;
      w_shift        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               sprite_x_d = sprite_x;
               size_x_d   = size_x;
               t_d        = 3'd0;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            current_tile_d = 4'd0;
            state_d        = ST_FETCH;
         end
         ST_FETCH: begin
            p_d     = 3'd0;
            state_d = ST_PIX;
         end
         ST_PIX: begin
            w_load  = (p_q == 3'd0);
            w_shift = (p_q != 3'd0);
            p_d     = p_q + 3'd1;
`ifdef PREFETCH_EN
            // Present the next tile during the last pixel so its row lands exactly at p=0.
            if (p_q == 3'd6 && t_q != size_x_q) begin
               current_tile_d = {1'b0, t_q} + 4'd1;
            end
`endif
            if (p_q == 3'd7) begin
               if (t_q == size_x_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  t_d = t_q + 3'd1;
`ifdef PREFETCH_EN
                  state_d = ST_PIX;
`else
                  current_tile_d = {1'b0, t_q} + 4'd1;
                  state_d        = ST_FETCH;
`endif
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         sprite_x_q     <= '0;
         size_x_q       <= '0;
         t_q            <= '0;
         p_q            <= '0;
         done_q         <= 1'b0;
         current_tile_q <= '0;
      end else begin
         state_q        <= state_d;
         sprite_x_q     <= sprite_x_d;
         size_x_q       <= size_x_d;
         t_q            <= t_d;
         p_q            <= p_d;
         done_q         <= done_d;
         current_tile_q <= current_tile_d;
      end
   end

   tile_pixel_shifter u_shifter (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_row   (tile_data),
      .o_pixel (w_pixel)
   );

   // Widened so that sprites starting near the right edge clip rather than wrap.
   assign w_x = {4'b0000, sprite_x_q}
              + {{(XW-2){1'b0}}, t_q, 3'b000}
              + {{(XW+1){1'b0}}, p_q};

   assign w_in_pix     = (state_q == ST_PIX);
   assign lb_we        = w_in_pix && (w_pixel != TRANSPARENT_IDX) && (w_x < c_LINE_LIMIT);
   assign lb_addr      = w_in_pix ? w_x[XW-1:0] : '0;
   assign lb_wdata     = w_in_pix ? w_pixel : '0;
   assign tile_load    = (state_q == ST_LOAD);
   assign busy         = (state_q != ST_IDLE) || done_q;
   assign done         = done_q;
   assign current_tile = current_tile_q;

endmodule
`default_nettype wire
